max_pool_stream: RTL and testbench
==================================

// Module: max_pool_stream
// PURPOSE
//  Streaming KxK max-pool (stride K) over a row-major feature map, CH channels per beat.
//  Sits between a conv/activation stage and the next layer in the LeNet datapath.
//  Replaces fixed 2x2 pooling: parametrised window, width, channels and image size.
//  Adds ready/valid flow control, optional ReLU clamp and frame-done signalling.
// PARAMETERS
//  DW     16  bits per channel sample, signed two's complement
//  CH     2   channels packed per beat; ch i occupies bits [i*DW +: DW]
//  POOL   2   window size and stride, >=2
//  IMG_W  24  input columns; must be a multiple of POOL
//  IMG_H  24  input rows; must be a multiple of POOL
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  clr        in   1          sync restart: zero counters and partials, drop out_valid
//  relu_en    in   1          1: clamp negative results to 0; sample at window completion
//  in_valid   in   1          input beat valid
//  in_ready   out  1          block accepts beat
//  in_data    in   CH*DW      one pixel, all channels
//  out_valid  out  1          pooled result valid
//  out_ready  in   1          downstream accepts result
//  out_data   out  CH*DW      pooled pixel, all channels
//  frame_done out  1          1-cycle pulse when last result of a frame is accepted
// BEHAVIOUR
//  - One clock domain; rst_n is asynchronous and active-low.
//  - Reset or clr: counters, partial buffer, out_data = 0; out_valid = 0; frame_done = 0.
//  - clr has priority over all other activity in the same cycle.
//  - Input beat is accepted when in_valid & in_ready.
//  - in_ready = !out_valid | out_ready. Combinational; no in_valid -> in_ready path.
//  - Counters:
//    - col: 0..IMG_W-1.
//    - wr (row within window): 0..POOL-1.
//    - orow (output row): 0..IMG_H/POOL-1.
//    - All advance only on an accepted beat. All wrap to 0 at frame end.
//  - Partial buffer: IMG_W/POOL entries of CH*DW, indexed by col/POOL.
//    - Also holds a running register for the current horizontal window.
//  - Per channel, on each accepted beat:
//    - If first pixel of the window (col%POOL==0 and wr==0): partial = pixel.
//    - Otherwise: partial = signed max(partial, pixel).
//    - Ties keep the stored value.
//  - Window completes on the beat where col%POOL==POOL-1 and wr==POOL-1.
//    - The next cycle: out_valid=1, out_data = max (ReLU applied if relu_en).
//    - Latency is 1 cycle from the completing beat.
//  - out_valid/out_data hold until out_valid & out_ready.
//    - If a new window completes in the same cycle: reload, out_valid stays 1.
//  - Channels are independent. Comparison is full-width signed.
//    - Example: 0x8000 < 0xFFFF < 0x0000 < 0x7FFF.
//  - frame_done pulses for 1 cycle on the handshake of output (IMG_H/POOL-1, IMG_W/POOL-1).
//  - Reset mid-frame discards partials; the next accepted beat is pixel (0,0).
//  - Back-to-back frames need no idle cycle.
//  - Throughput: 1 beat/cycle when out_ready is held 1.
// TESTING
//  - POOL=2, CH=2, IMG 4x4, in ch0 = 0..15 row-major, ch1 = -ch0, out_ready=1:
//    - ch0 out = 5,7,13,15.
//    - ch1 out = 0,-2,-8,-10.
//    - frame_done pulses once, with the 4th output.
//  - All-negative window {0x8000,0xFFFF,0xFFFE,0x8001}:
//    - relu_en=0 -> 0xFFFF.
//    - relu_en=1 -> 0x0000.
//  - Hold out_ready=0 for 5 cycles when the first result is pending:
//    - in_ready drops; out_data stable; no beats lost.
//    - Remaining outputs correct after release.
//  - POOL=3, IMG 6x6, random signed data, random in_valid/out_ready gaps:
//    - Outputs match a software golden model, bit-exact, in order.
//  - rst_n low asynchronously mid-frame (after 7 beats):
//    - Outputs 0 immediately.
//    - A fresh full frame then pools correctly.
//  - clr asserted together with a window-completing beat:
//    - No output is produced.
//    - The next beat is treated as pixel (0,0).

Source files
------------

// File: rtl/max_pool_stream.sv
// Streaming POOLxPOOL max-pool with stride POOL over a row-major image, CH signed channels per beat.
// A per-column partial buffer carries window maxima across rows; the running register covers the current row segment.
module max_pool_stream #(
  parameter int DW    = 16,
  parameter int CH    = 2,
  parameter int POOL  = 2,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             relu_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             frame_done
);
  localparam int NW = IMG_W / POOL;
  localparam int NH = IMG_H / POOL;
  localparam int PW = $clog2(POOL);
  localparam int XW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RW = (NH > 1) ? $clog2(NH) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(POOL - 1);
  localparam logic [XW-1:0] X_LAST = XW'(NW - 1);
  localparam logic [RW-1:0] R_LAST = RW'(NH - 1);

  // The column counter is kept split as (window index, offset within window).
  logic [PW-1:0]    pc_q, pc_d;
  logic [XW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [RW-1:0]    orow_q, orow_d;
  logic [CH*DW-1:0] run_q, run_d;
  logic             out_valid_q, out_valid_d;
  logic [CH*DW-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CH*DW-1:0] part_q [NW];

  logic             accept;
  logic             first_px;
  logic             win_done;
  logic             part_we;
  logic [CH*DW-1:0] cur_all;
  logic [CH*DW-1:0] res_all;

  assign in_ready   = !out_valid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign first_px   = (pc_q == '0) && (wr_q == '0);
  assign win_done   = accept && (pc_q == P_LAST) && (wr_q == P_LAST);
  assign part_we    = accept && (pc_q == P_LAST) && !clr;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = out_valid_q & out_ready & out_last_q & !clr;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [DW-1:0] pix, prev, cur, res;
      assign pix  = in_data[gi*DW +: DW];
      // At a window's left edge the previous maximum comes from the rows above.
      assign prev = (pc_q == '0) ? part_q[idx_q][gi*DW +: DW] : run_q[gi*DW +: DW];
      assign cur  = first_px ? pix : ((pix > prev) ? pix : prev);
      assign res  = (relu_en && cur[DW-1]) ? '0 : cur;
      assign cur_all[gi*DW +: DW] = cur;
      assign res_all[gi*DW +: DW] = res;
    end
  endgenerate

  always_comb begin
    pc_d        = pc_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    orow_d      = orow_q;
    run_d       = run_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      run_d = cur_all;
      if (pc_q == P_LAST) begin
        pc_d = '0;
        if (idx_q == X_LAST) begin
          idx_d = '0;
          if (wr_q == P_LAST) begin
            wr_d   = '0;
            orow_d = (orow_q == R_LAST) ? '0 : orow_q + RW'(1);
          end else begin
            wr_d = wr_q + PW'(1);
          end
        end else begin
          idx_d = idx_q + XW'(1);
        end
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = res_all;
      out_last_d  = (orow_q == R_LAST) && (idx_q == X_LAST);
    end
    if (clr) begin
      pc_d        = '0;
      idx_d       = '0;
      wr_d        = '0;
      orow_d      = '0;
      run_d       = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      idx_q       <= '0;
      wr_q        <= '0;
      orow_q      <= '0;
      run_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      orow_q      <= orow_d;
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) part_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NW; i++) part_q[i] <= '0;
    end else if (part_we) begin
      part_q[idx_q] <= cur_all;
    end
  end
endmodule

// File: tb/tb_max_pool_stream.sv
// Scoreboard bench: a 4x4 POOL=2 instance for directed scenarios and a 6x6 POOL=3 instance for random traffic.
module tb_max_pool_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr;
  logic        relu_a, iv_a, ir_a, ov_a, or_a, fd_a;
  logic [31:0] id_a, od_a;
  logic        relu_b, iv_b, ir_b, ov_b, or_b, fd_b;
  logic [31:0] id_b, od_b;

  int checks = 0;
  int errors = 0;
  int fd_cnt_a = 0;
  int fd_cnt_b = 0;
  int stall_a = 0;
  bit rand_rdy_b = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  logic signed [15:0] f0 [64];
  logic signed [15:0] f1 [64];

  max_pool_stream #(.DW(16), .CH(2), .POOL(2), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .relu_en(relu_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .frame_done(fd_a)
  );

  max_pool_stream #(.DW(16), .CH(2), .POOL(3), .IMG_W(6), .IMG_H(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .relu_en(relu_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .frame_done(fd_b)
  );

  // Scoreboard pops: a handshake happens at the posedge following this negedge.
  always @(negedge clk) begin
    if (rst_n && ov_a && or_a) begin
      exp_t e;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL out_a_unexpected: got data=%h, expected no output", od_a);
      end else begin
        e = qa.pop_front();
        if (od_a !== e.data || fd_a !== e.last) begin
          errors++;
          $display("FAIL out_a: got data=%h fd=%b, expected data=%h fd=%b", od_a, fd_a, e.data, e.last);
        end
      end
    end
    if (fd_a === 1'b1) fd_cnt_a++;
  end

  always @(negedge clk) begin
    if (rst_n && ov_b && or_b) begin
      exp_t e;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL out_b_unexpected: got data=%h, expected no output", od_b);
      end else begin
        e = qb.pop_front();
        if (od_b !== e.data || fd_b !== e.last) begin
          errors++;
          $display("FAIL out_b: got data=%h fd=%b, expected data=%h fd=%b", od_b, fd_b, e.data, e.last);
        end
      end
    end
    if (fd_b === 1'b1) fd_cnt_b++;
  end

  always @(posedge clk) begin
    if (rand_rdy_b) begin
      #1;
      or_b = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Direct window-by-window golden model over the frame arrays.
  task automatic model_push(input int which, input int p, input int w, input int h, input bit relu);
    logic signed [15:0] m0, m1, v0, v1;
    exp_t e;
    for (int r = 0; r < h / p; r++) begin
      for (int c = 0; c < w / p; c++) begin
        m0 = f0[r * p * w + c * p];
        m1 = f1[r * p * w + c * p];
        for (int dy = 0; dy < p; dy++) begin
          for (int dx = 0; dx < p; dx++) begin
            v0 = f0[(r * p + dy) * w + c * p + dx];
            v1 = f1[(r * p + dy) * w + c * p + dx];
            if (v0 > m0) m0 = v0;
            if (v1 > m1) m1 = v1;
          end
        end
        if (relu && m0 < 0) m0 = 16'sd0;
        if (relu && m1 < 0) m1 = 16'sd0;
        e.data = {m1, m0};
        e.last = (r == h / p - 1) && (c == w / p - 1);
        if (which == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
  endtask

  task automatic ramp_frame();
    for (int i = 0; i < 16; i++) begin
      f0[i] = 16'(i);
      f1[i] = -16'(i);
    end
  endtask

  task automatic beat_a(input logic [31:0] d);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    iv_a = 1'b1;
    id_a = d;
    while (!ok) begin
      @(negedge clk);
      ok = ir_a;
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL beat_a_timeout: in_ready=%b after %0d cycles, expected 1", ir_a, n);
        break;
      end
    end
    if (n > 1) stall_a++;
  endtask

  task automatic beat_b(input logic [31:0] d);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    iv_b = 1'b1;
    id_b = d;
    while (!ok) begin
      @(negedge clk);
      ok = ir_b;
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL beat_b_timeout: in_ready=%b after %0d cycles, expected 1", ir_b, n);
        break;
      end
    end
  endtask

  task automatic drive_frame_a();
    for (int i = 0; i < 16; i++) beat_a({f1[i], f0[i]});
    iv_a = 1'b0;
  endtask

  task automatic drive_frame_b();
    for (int i = 0; i < 36; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        iv_b = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      beat_b({f1[i], f0[i]});
    end
    iv_b = 1'b0;
  endtask

  task automatic drain_a();
    int n = 0;
    while (qa.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL drain_a: %0d results outstanding, expected 0", qa.size());
      qa.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    int n = 0;
    while (qb.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL drain_b: %0d results outstanding, expected 0", qb.size());
      qb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    relu_a = 1'b0; iv_a = 1'b0; id_a = '0; or_a = 1'b1;
    relu_b = 1'b0; iv_b = 1'b0; id_b = '0; or_b = 1'b1;
    #12;
    checks++;
    if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", ov_a); end
    checks++;
    if (od_a !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h, expected 0", od_a); end
    checks++;
    if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, expected 0", fd_a); end
    checks++;
    if (ir_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", ir_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int c0[4] = '{5, 7, 13, 15};
    int c1[4] = '{0, -2, -8, -10};
    exp_t e;
    ramp_frame();
    for (int k = 0; k < 4; k++) begin
      e.data = {c1[k][15:0], c0[k][15:0]};
      e.last = (k == 3);
      qa.push_back(e);
    end
    fd_cnt_a = 0;
    stall_a = 0;
    drive_frame_a();
    drain_a();
    checks++;
    if (fd_cnt_a != 1) begin errors++; $display("FAIL basic_frame_done: got %0d pulses, expected 1", fd_cnt_a); end
    checks++;
    if (stall_a != 0) begin errors++; $display("FAIL basic_throughput: got %0d stalled beats, expected 0", stall_a); end
  endtask

  task automatic test_back_to_back();
    fd_cnt_a = 0;
    stall_a = 0;
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 16; i++) begin
        f0[i] = 16'($urandom);
        f1[i] = 16'($urandom);
      end
      model_push(0, 2, 4, 4, 1'b0);
      drive_frame_a();
    end
    drain_a();
    checks++;
    if (fd_cnt_a != 2) begin errors++; $display("FAIL b2b_frame_done: got %0d pulses, expected 2", fd_cnt_a); end
    checks++;
    if (stall_a != 0) begin errors++; $display("FAIL b2b_throughput: got %0d stalled beats, expected 0", stall_a); end
  endtask

  task automatic test_relu();
    for (int rl = 0; rl < 2; rl++) begin
      for (int i = 0; i < 16; i++) begin
        f0[i] = 16'sd0;
        f1[i] = 16'sd0;
      end
      f0[0] = 16'sh8000; f0[1] = 16'shFFFF; f0[4] = 16'shFFFE; f0[5] = 16'sh8001;
      f1[2] = 16'sh8000; f1[3] = 16'shFFFF; f1[6] = 16'shFFFE; f1[7] = 16'sh8001;
      relu_a = rl[0];
      model_push(0, 2, 4, 4, rl[0]);
      drive_frame_a();
      drain_a();
    end
    relu_a = 1'b0;
  endtask

  task automatic test_backpressure();
    ramp_frame();
    model_push(0, 2, 4, 4, 1'b0);
    or_a = 1'b0;
    fork
      drive_frame_a();
      begin
        int n;
        logic [31:0] held;
        n = 0;
        @(negedge clk);
        while (!ov_a && n < 100) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (!ov_a) begin errors++; $display("FAIL bp_first_result: out_valid=%b, expected 1", ov_a); end
        held = od_a;
        repeat (5) begin
          checks++;
          if (ir_a !== 1'b0 || od_a !== held) begin
            errors++;
            $display("FAIL bp_hold: got in_ready=%b data=%h, expected in_ready=0 data=%h", ir_a, od_a, held);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        or_a = 1'b1;
      end
    join
    drain_a();
  endtask

  task automatic test_async_reset();
    exp_t e;
    ramp_frame();
    e.data = {16'h0000, 16'h0005};
    e.last = 1'b0;
    qa.push_back(e);
    for (int i = 0; i < 7; i++) beat_a({f1[i], f0[i]});
    iv_a = 1'b0;
    checks++;
    if (qa.size() != 0) begin errors++; $display("FAIL arst_pre: %0d results outstanding, expected 0", qa.size()); end
    qa.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov_a !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b, expected 0", ov_a); end
    checks++;
    if (od_a !== 32'h0) begin errors++; $display("FAIL arst_out_data: got %h, expected 0", od_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_push(0, 2, 4, 4, 1'b0);
    drive_frame_a();
    drain_a();
  endtask

  task automatic test_clr();
    ramp_frame();
    for (int i = 0; i < 5; i++) beat_a({f1[i], f0[i]});
    clr = 1'b1;
    beat_a({f1[5], f0[5]});
    clr = 1'b0;
    iv_a = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (ov_a !== 1'b0) begin errors++; $display("FAIL clr_no_output: out_valid=%b, expected 0", ov_a); end
    end
    @(posedge clk);
    #1;
    model_push(0, 2, 4, 4, 1'b0);
    drive_frame_a();
    drain_a();
  endtask

  task automatic test_random_pool3();
    fd_cnt_b = 0;
    rand_rdy_b = 1'b1;
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 36; i++) begin
        f0[i] = 16'($urandom);
        f1[i] = 16'($urandom);
      end
      model_push(1, 3, 6, 6, 1'b0);
      drive_frame_b();
    end
    rand_rdy_b = 1'b0;
    @(posedge clk);
    #1;
    or_b = 1'b1;
    drain_b();
    checks++;
    if (fd_cnt_b != 2) begin errors++; $display("FAIL pool3_frame_done: got %0d pulses, expected 2", fd_cnt_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_relu();
    test_backpressure();
    test_async_reset();
    test_clr();
    test_random_pool3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
